// File: rtl/instr_loader.sv
// Program loader: assembles little-endian 32-bit words from a byte stream and
// drives the instruction-memory init write port until HALT or memory full.
module instr_loader #(
  parameter int unsigned  NB_ADDR   = 8,
  parameter int unsigned  ADDR_STEP = 4,
  parameter logic [31:0]  HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_we,
  output logic [31:0]        o_inst_addr,
  output logic [31:0]        o_instr_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_ADDR:0]   o_word_count
);

  localparam logic [NB_ADDR:0]   MAX_WORDS = (NB_ADDR+1)'((2**NB_ADDR) / ADDR_STEP);
  localparam logic [NB_ADDR-1:0] STEP      = NB_ADDR'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         idx_p0;
  logic [23:0]        lanes_p0;
  logic [NB_ADDR-1:0] addr_p0;
  logic [NB_ADDR:0]   word_count;
  logic               vld_p1;
  logic [31:0]        word_p1;
  logic [31:0]        addr_p1;

  logic               term;
  logic               accept;
  logic               word_last;
  logic               clear;

  // The word being written in this cycle decides termination; its count is
  // still the pre-write value, so "this write fills memory" is count+1 == MAX.
  always_comb begin
    term      = vld_p1 && ((word_p1 == HALT_WORD) || (word_count + 1'b1 == MAX_WORDS));
    accept    = (state == LOAD) && i_rx_valid && !term;
    word_last = accept && (idx_p0 == 2'd3);
    clear     = (state != LOAD) && i_start;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = LOAD;
      LOAD:    if (term)    state_nxt = DONE;
      DONE:    if (i_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      idx_p0     <= 2'd0;
      lanes_p0   <= 24'd0;
      addr_p0    <= '0;
      word_count <= '0;
      vld_p1     <= 1'b0;
      word_p1    <= 32'd0;
      addr_p1    <= 32'd0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= word_last;
      if (clear) begin
        idx_p0     <= 2'd0;
        addr_p0    <= '0;
        word_count <= '0;
      end else begin
        // p0: byte assembly
        if (accept) begin
          idx_p0 <= idx_p0 + 2'd1;
          case (idx_p0)
            2'd0:    lanes_p0[7:0]   <= i_rx_data;
            2'd1:    lanes_p0[15:8]  <= i_rx_data;
            2'd2:    lanes_p0[23:16] <= i_rx_data;
            default: lanes_p0        <= lanes_p0;
          endcase
        end
        // p1: completed word presented on the write port
        if (word_last) begin
          word_p1 <= {i_rx_data, lanes_p0};
          addr_p1 <= {{(32-NB_ADDR){1'b0}}, addr_p0};
          addr_p0 <= addr_p0 + STEP;
        end
        if (vld_p1) word_count <= word_count + 1'b1;
      end
    end
  end

  assign o_we         = vld_p1;
  assign o_inst_addr  = addr_p1;
  assign o_instr_data = word_p1;
  assign o_busy       = (state == LOAD);
  assign o_done       = (state == DONE);
  assign o_word_count = word_count;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued by the stimulus
// and popped by a monitor whenever the write strobe is seen.
module tb_instr_loader;

  logic        clk;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_we;
  logic [31:0] o_inst_addr;
  logic [31:0] o_instr_data;
  logic        o_busy;
  logic        o_done;
  logic [8:0]  o_word_count;

  instr_loader #(.NB_ADDR(8), .ADDR_STEP(4), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_we         (o_we),
    .o_inst_addr  (o_inst_addr),
    .o_instr_data (o_instr_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_word_count (o_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  always @(negedge clk) begin
    if (o_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_we: got addr=%h data=%h, required no write", o_inst_addr, o_instr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (o_inst_addr !== e.addr || o_instr_data !== e.data) begin
          fails++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   o_inst_addr, o_instr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    step();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a);
    wr_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    {31'd0, o_we},    32'd0);
    check({tag, "_addr"},  o_inst_addr,      32'd0);
    check({tag, "_data"},  o_instr_data,     32'd0);
    check({tag, "_busy"},  {31'd0, o_busy},  32'd0);
    check({tag, "_done"},  {31'd0, o_done},  32'd0);
    check({tag, "_count"}, {23'd0, o_word_count}, 32'd0);
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'd0;
    idle(2);
    check_all_zero("reset");
    i_rst_n = 1'b1;

    // Bytes in IDLE are discarded.
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(3);
    check("idle_busy", {31'd0, o_busy}, 32'd0);

    // Basic load: one instruction then HALT.
    pulse_start();
    check("start_busy", {31'd0, o_busy}, 32'd1);
    send_word(32'h2000_0013, 32'h0);
    send_word(32'hFFFF_FFFF, 32'h4);
    check("halt_we_cycle_done", {31'd0, o_done}, 32'd0);
    step();
    check("t1_done",  {31'd0, o_done}, 32'd1);
    check("t1_busy",  {31'd0, o_busy}, 32'd0);
    check("t1_count", {23'd0, o_word_count}, 32'd2);

    // Bytes in DONE are discarded; outputs hold.
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(3);
    check("done_hold_addr", o_inst_addr, 32'h4);
    check("done_hold_data", o_instr_data, 32'hFFFF_FFFF);

    // Back-to-back bytes every cycle, restart from DONE.
    pulse_start();
    check("restart_count", {23'd0, o_word_count}, 32'd0);
    send_word(32'h0403_0201, 32'h0);
    send_word(32'h0807_0605, 32'h4);
    send_word(32'hFFFF_FFFF, 32'h8);
    step();
    check("t2_done",  {31'd0, o_done}, 32'd1);
    check("t2_count", {23'd0, o_word_count}, 32'd3);

    // Fill memory with 64 non-HALT words.
    pulse_start();
    for (int i = 0; i < 64; i++)
      send_word(32'h1000_0000 + i, 32'(i * 4));
    check("fill_count_pre", {23'd0, o_word_count}, 32'd63);
    step();
    check("fill_done",  {31'd0, o_done}, 32'd1);
    check("fill_count", {23'd0, o_word_count}, 32'd64);
    check("fill_addr",  o_inst_addr, 32'h0000_00FC);
    send_byte(8'h5A); send_byte(8'h5B); send_byte(8'h5C); send_byte(8'h5D);
    idle(3);

    // Reset in the middle of the second word.
    pulse_start();
    send_word(32'h1122_3344, 32'h0);
    send_byte(8'h77); send_byte(8'h66);
    i_rst_n = 1'b0;
    step();
    check_all_zero("midreset");
    i_rst_n = 1'b1;

    // Start and byte in the same IDLE cycle: byte discarded.
    i_start    = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h55;
    step();
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    send_word(32'hDDCC_BBAA, 32'h0);
    send_word(32'hFFFF_FFFF, 32'h4);
    step();
    check("t4_done",  {31'd0, o_done}, 32'd1);
    check("t4_count", {23'd0, o_word_count}, 32'd2);

    // Restart from DONE straight into HALT.
    pulse_start();
    send_word(32'hFFFF_FFFF, 32'h0);
    step();
    check("t5_done",  {31'd0, o_done}, 32'd1);
    check("t5_count", {23'd0, o_word_count}, 32'd1);

    // i_start during LOAD is ignored.
    pulse_start();
    send_word(32'h0000_0093, 32'h0);
    pulse_start();
    send_byte(8'h13);
    send_byte(8'h01);
    i_start = 1'b1;
    send_byte(8'h00);
    i_start = 1'b0;
    exp_q.push_back('{addr: 32'h4, data: 32'h0000_0113});
    send_byte(8'h00);
    step();
    check("t6_count", {23'd0, o_word_count}, 32'd2);
    check("t6_busy",  {31'd0, o_busy}, 32'd1);
    send_word(32'hFFFF_FFFF, 32'h8);
    step();
    check("t6_done",  {31'd0, o_done}, 32'd1);
    check("t6_count_end", {23'd0, o_word_count}, 32'd3);

    idle(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
